complex_vector_chunk_feeder: RTL and testbench
==============================================

# complex_vector_chunk_feeder

Upstream operand feeder for the 8-lane complex vector-times-constant add stage. Holds two NOE-element complex vectors (first row, second row) and one complex constant, loaded one element per cycle through a write port. On `start` it streams the vectors as NI-element chunks, zero-padding the tail lanes of the last chunk, under a valid/ready handshake. It raises a one-cycle `done` after the last chunk is accepted.

## Interface
Parameters:
- NOE, 19: elements per vector.
- NI, 8: lanes per chunk.
- element_width, 64: complex element width; real in [63:32], imag in [31:0], each IEEE-754 single.
- derived NCH = (NOE+NI-1)/NI: chunk count. No extra all-zero chunk when NOE%NI==0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- wr_en  in  1  element write strobe.
- wr_sel  in  2  write target: 0 first row, 1 second row, 2 constant, 3 reserved (write ignored).
- wr_addr  in  $clog2(NOE)  element index; ignored for the constant.
- wr_data  in  element_width  element value.
- start  in  1  begin streaming; sampled only in IDLE.
- out_ready  in  1  consumer accepts the current chunk.
- out_valid  out  1  chunk outputs are valid.
- first_row_out  out  element_width*NI  first-row chunk; lane j at [element_width*(NI-j)-1 -: element_width].
- second_row_out  out  element_width*NI  second-row chunk, same lane mapping.
- constant_out  out  element_width  constant register; held stable throughout streaming.
- last_chunk  out  1  current chunk is chunk NCH-1.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last chunk is accepted.
- wr_err  out  1  one-cycle pulse: a write was dropped (busy, wr_sel==3, or wr_addr>=NOE).

## Operation
- Storage: two NOE×element_width register arrays plus the constant register; all reset to 0.
- Writes apply in IDLE only. While busy a write is dropped and wr_err pulses the next cycle.
- FSM states: IDLE, STREAM, DONE.
  - IDLE -> STREAM on start: chunk index c=0; the outputs register chunk 0.
  - STREAM, out_valid&&out_ready, c<NCH-1: c+1 and the next chunk is registered.
  - STREAM, handshake on c==NCH-1 -> DONE; out_valid drops.
  - DONE -> IDLE unconditionally; done=1 for exactly this cycle.
- Chunk c, lane j carries element c*NI+j if that index is < NOE, otherwise 64'h0. Both rows are padded identically.
- Without ready, the outputs, last_chunk and c hold stable.
- start while busy is ignored. start and wr_en in the same IDLE cycle: the write completes, and streaming uses the new value.
- Reset asserted mid-stream: immediately returns to IDLE and clears the arrays, outputs and flags. No done pulse.

## Timing
- Reset values: out_valid, last_chunk, busy, done, wr_err = 0; all data outputs = 0.
- start in cycle T: out_valid=1 and chunk 0 visible from T+1. busy=1 from T+1.
- With out_ready held high, chunk k is visible in cycle T+1+k. Done pulses in T+1+NCH. busy falls in T+2+NCH.
- A write in cycle T is readable by a start in cycle T+1 or later.
- All outputs are registered; there is no combinational path from out_ready to any output.

## Structure
- Shared package cplx_pkg: element_width, NI, the real/imag field positions, the COMPLEX_ZERO constant, and the feeder state enum.
- One sub-module, cplx_vector_regfile: NOE-entry write port plus an NI-wide padded chunk read port (chunk index in, NI lanes out). Instantiated twice, once per row. The FSM and handshake live in the top module.

## Test plan
- Load first row with element i = {i, 0} and second row with {0, i} for i=0..18, constant = 64'h3F800000_00000000. start, out_ready=1: chunks 0,1,2 appear on consecutive cycles, chunk 2 lanes 0–2 = elements 16–18 and lanes 3–7 = 0, last_chunk only on chunk 2, done 1 cycle after.
- Same load, out_ready low for 3 cycles on chunk 1: outputs hold, no skipped or duplicated chunk, done delayed by 3 cycles.
- NOE=16 build: exactly 2 chunks with no padded lanes; done after chunk 1.
- Write during STREAM, and write with wr_addr=19 in IDLE: wr_err pulses once each, storage unchanged (verified by a following stream).
- Reset low during chunk 1: out_valid, busy, done = 0 immediately, arrays read back as 0 on the next stream, no done pulse.
- start asserted again while busy: no restart; exactly NCH chunks and one done.

Source files
------------

// File: rtl/cplx_pkg.sv
// Shared definitions for the complex vector chunk feeder: element layout,
// default lane count, the zero element and the feeder state encoding.
package cplx_pkg;

  localparam int CPLX_ELEMENT_WIDTH = 64;
  localparam int CPLX_NI            = 8;

  // Real part in the upper half, imaginary part in the lower half.
  localparam int CPLX_RE_MSB = 63;
  localparam int CPLX_RE_LSB = 32;
  localparam int CPLX_IM_MSB = 31;
  localparam int CPLX_IM_LSB = 0;

  localparam logic [CPLX_ELEMENT_WIDTH-1:0] COMPLEX_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_t;

  function automatic logic [CPLX_ELEMENT_WIDTH-1:0] cplx_pack(input logic [31:0] re,
                                                              input logic [31:0] im);
    logic [CPLX_ELEMENT_WIDTH-1:0] v;
    v = COMPLEX_ZERO;
    v[CPLX_RE_MSB:CPLX_RE_LSB] = re;
    v[CPLX_IM_MSB:CPLX_IM_LSB] = im;
    return v;
  endfunction

endpackage

// File: rtl/cplx_vector_regfile.sv
// NOE-entry complex element store with one write port and an NI-lane chunk
// read port; lanes past the last element read as zero.
module cplx_vector_regfile
  import cplx_pkg::*;
#(
  parameter int NOE           = 19,
  parameter int NI            = CPLX_NI,
  parameter int element_width = CPLX_ELEMENT_WIDTH,
  localparam int NCH          = (NOE + NI - 1) / NI,
  localparam int AW           = $clog2(NOE),
  localparam int KW           = $clog2(NCH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [element_width-1:0]      wr_data,
  input  logic [KW-1:0]                 rd_chunk,
  output logic [element_width*NI-1:0]   rd_data
);

  // Storage is rounded up to whole chunks; entries at NOE and above are
  // never written, so they stay zero and supply the tail padding for free.
  localparam int DEPTH = NCH * NI;

  logic [element_width-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NOE; i++) begin
        if (wr_en && int'(wr_addr) == i) mem[i] <= wr_data;
      end
    end
  end

  // A write in the same cycle is forwarded so a start alongside a write
  // registers the new value into chunk 0.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(rd_chunk) == c) begin
        for (int j = 0; j < NI; j++) begin
          rd_data[element_width*(NI-j)-1 -: element_width] =
            (wr_en && int'(wr_addr) == c*NI + j) ? wr_data : mem[c*NI + j];
        end
      end
    end
  end

endmodule

// File: rtl/complex_vector_chunk_feeder.sv
// Operand feeder: stores two complex rows plus a constant and streams the
// rows as zero-padded NI-lane chunks under a valid/ready handshake.
//
// state     | meaning
// ST_IDLE   | accepting writes, waiting for start
// ST_STREAM | presenting chunk chunk_idx with out_valid high
// ST_DONE   | last chunk accepted, done pulse, return to idle
module complex_vector_chunk_feeder
  import cplx_pkg::*;
#(
  parameter int NOE           = 19,
  parameter int NI            = CPLX_NI,
  parameter int element_width = CPLX_ELEMENT_WIDTH,
  localparam int NCH          = (NOE + NI - 1) / NI,
  localparam int AW           = $clog2(NOE),
  localparam int KW           = $clog2(NCH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_sel,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [element_width-1:0]      wr_data,
  input  logic                          start,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [element_width*NI-1:0]   first_row_out,
  output logic [element_width*NI-1:0]   second_row_out,
  output logic [element_width-1:0]      constant_out,
  output logic                          last_chunk,
  output logic                          busy,
  output logic                          done,
  output logic                          wr_err
);

  feeder_state_t state;
  logic [KW-1:0] chunk_idx;
  logic [KW-1:0] rd_chunk;
  logic [element_width*NI-1:0] row0_rd;
  logic [element_width*NI-1:0] row1_rd;
  logic is_idle, addr_ok, row0_we, row1_we, const_we, wr_drop;
  logic handshake, is_last;

  always_comb begin
    is_idle   = (state == ST_IDLE);
    addr_ok   = (int'(wr_addr) < NOE);
    row0_we   = wr_en && is_idle && (wr_sel == 2'd0) && addr_ok;
    row1_we   = wr_en && is_idle && (wr_sel == 2'd1) && addr_ok;
    const_we  = wr_en && is_idle && (wr_sel == 2'd2);
    wr_drop   = wr_en && !(row0_we || row1_we || const_we);
    handshake = out_valid && out_ready;
    is_last   = (chunk_idx == KW'(NCH - 1));
    // The read port always looks one chunk ahead of what is on the outputs.
    rd_chunk  = is_idle ? '0 : chunk_idx + KW'(1);
  end

  cplx_vector_regfile #(
    .NOE           (NOE),
    .NI            (NI),
    .element_width (element_width)
  ) u_row0 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (row0_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_chunk (rd_chunk),
    .rd_data  (row0_rd)
  );

  cplx_vector_regfile #(
    .NOE           (NOE),
    .NI            (NI),
    .element_width (element_width)
  ) u_row1 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (row1_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_chunk (rd_chunk),
    .rd_data  (row1_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      chunk_idx      <= '0;
      out_valid      <= 1'b0;
      first_row_out  <= '0;
      second_row_out <= '0;
      constant_out   <= '0;
      last_chunk     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wr_err         <= 1'b0;
    end else begin
      wr_err <= wr_drop;
      done   <= 1'b0;
      if (const_we) constant_out <= wr_data;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_STREAM;
            chunk_idx      <= '0;
            first_row_out  <= row0_rd;
            second_row_out <= row1_rd;
            out_valid      <= 1'b1;
            last_chunk     <= (NCH == 1);
            busy           <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (handshake) begin
            if (is_last) begin
              state      <= ST_DONE;
              out_valid  <= 1'b0;
              last_chunk <= 1'b0;
              done       <= 1'b1;
            end else begin
              chunk_idx      <= chunk_idx + KW'(1);
              first_row_out  <= row0_rd;
              second_row_out <= row1_rd;
              last_chunk     <= (chunk_idx == KW'(NCH - 2));
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_vector_chunk_feeder.sv
// Self-checking bench: element-level reference model of both rows and the
// constant, directed scenarios with randomized data and ready patterns.
module tb_complex_vector_chunk_feeder;
  import cplx_pkg::*;

  localparam int NOE    = 19;
  localparam int NI     = 8;
  localparam int W      = 64;
  localparam int NCH    = 3;
  localparam int NCH16  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [1:0]    wr_sel = '0;
  logic [4:0]    wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          use16 = 1'b0;

  logic              out_valid, last_chunk, busy, done, wr_err;
  logic [W*NI-1:0]   first_row_out, second_row_out;
  logic [W-1:0]      constant_out;

  logic              wr_en16, start16;
  logic              out_valid16, last_chunk16, busy16, done16, wr_err16;
  logic [W*NI-1:0]   first_row_out16, second_row_out16;
  logic [W-1:0]      constant_out16;

  assign wr_en16 = wr_en && use16 && (wr_addr < 5'd16);
  assign start16 = start && use16;

  complex_vector_chunk_feeder #(.NOE(NOE), .NI(NI), .element_width(W)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .out_ready(out_ready), .out_valid(out_valid),
    .first_row_out(first_row_out), .second_row_out(second_row_out),
    .constant_out(constant_out), .last_chunk(last_chunk), .busy(busy), .done(done),
    .wr_err(wr_err)
  );

  complex_vector_chunk_feeder #(.NOE(16), .NI(NI), .element_width(W)) u_dut16 (
    .clk(clk), .reset(reset), .wr_en(wr_en16), .wr_sel(wr_sel), .wr_addr(wr_addr[3:0]),
    .wr_data(wr_data), .start(start16), .out_ready(out_ready), .out_valid(out_valid16),
    .first_row_out(first_row_out16), .second_row_out(second_row_out16),
    .constant_out(constant_out16), .last_chunk(last_chunk16), .busy(busy16), .done(done16),
    .wr_err(wr_err16)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m0 [NOE];
  logic [W-1:0] m1 [NOE];
  logic [W-1:0] cst;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_chunk(input bit row, input int c, input int noe);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < NI; j++) begin
      int idx;
      idx = c*NI + j;
      if (idx < noe) v[W*(NI-j)-1 -: W] = row ? m1[idx] : m0[idx];
    end
    return v;
  endfunction

  task automatic do_write(input logic [1:0] sel, input int addr, input logic [W-1:0] data);
    bit ok;
    ok = (sel != 2'd3) && (sel == 2'd2 || addr < NOE);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(addr); wr_data = data;
    if (ok) begin
      if (sel == 2'd0) m0[addr] = data;
      else if (sel == 2'd1) m1[addr] = data;
      else cst = data;
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_err_after_write", wr_err, !ok);
  endtask

  task automatic run_stream(input int stall_chunk, input int stall_len, input bit rand_ready,
                            input bit wr_start, input bit poke_start, input bit poke_write,
                            input int reset_chunk);
    int c, stalled, guard, a;
    bit exp_err, just_adv, r;
    logic [W-1:0] d;
    c = 0; stalled = 0; guard = 0; exp_err = 0; just_adv = 0;
    start = 1'b1;
    if (wr_start) begin
      a = $urandom_range(0, NI-1);
      d = {$urandom, $urandom};
      wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'(a); wr_data = d;
      m1[a] = d;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    while (c < NCH) begin
      guard++;
      if (guard > 100) begin
        errors++;
        $error("FAIL stream_timeout observed_chunk=%0d expected_chunk=%0d", c, NCH);
        break;
      end
      chk("out_valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("done_mid", done, 0);
      chk("last_chunk", last_chunk, c == NCH-1);
      chk("first_row", first_row_out, exp_chunk(0, c, NOE));
      chk("second_row", second_row_out, exp_chunk(1, c, NOE));
      chk("constant", constant_out, cst);
      chk("wr_err_stream", wr_err, exp_err);
      exp_err = 0;
      if (use16) begin
        if (c < NCH16) begin
          chk("n16_valid", out_valid16, 1);
          chk("n16_first", first_row_out16, exp_chunk(0, c, 16));
          chk("n16_second", second_row_out16, exp_chunk(1, c, 16));
          chk("n16_last", last_chunk16, c == NCH16-1);
          chk("n16_const", constant_out16, cst);
        end else if (just_adv) begin
          chk("n16_done", done16, 1);
          chk("n16_valid_off", out_valid16, 0);
          chk("n16_busy", busy16, 1);
        end
      end
      if (reset_chunk == c) begin
        reset = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", last_chunk, 0);
        chk("rst_first", first_row_out, 0);
        chk("rst_const", constant_out, 0);
        for (int i = 0; i < NOE; i++) begin m0[i] = '0; m1[i] = '0; end
        cst = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_no_done", done, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_no_done_after", done, 0);
        chk("rst_idle", busy, 0);
        return;
      end
      if (poke_start && c == 1) start = 1'b1;
      if (poke_write && c == 0) begin
        wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 5'd3; wr_data = {$urandom, $urandom};
        exp_err = 1;
      end
      if (rand_ready) r = 1'($urandom_range(0, 1));
      else if (c == stall_chunk && stalled < stall_len) begin r = 0; stalled++; end
      else r = 1;
      out_ready = r;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      just_adv = r;
      if (r) c++;
    end
    chk("done_pulse", done, 1);
    chk("valid_after_last", out_valid, 0);
    chk("busy_in_done", busy, 1);
    chk("last_after_last", last_chunk, 0);
    chk("wr_err_done", wr_err, exp_err);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_falls", busy, 0);
    chk("valid_idle", out_valid, 0);
    @(negedge clk);
    chk("no_restart", out_valid, 0);
    chk("done_idle", done, 0);
  endtask

  initial begin
    for (int i = 0; i < NOE; i++) begin m0[i] = '0; m1[i] = '0; end
    cst = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", last_chunk, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr_err", wr_err, 0);
    chk("reset_first", first_row_out, 0);
    chk("reset_second", second_row_out, 0);
    chk("reset_const", constant_out, 0);
    chk("reset_n16_valid", out_valid16, 0);
    chk("reset_n16_wr_err", wr_err16, 0);
    reset = 1'b1;
    @(negedge clk);

    // Reference load: first row {i,0}, second row {0,i}, constant 1.0+0i.
    use16 = 1'b1;
    for (int i = 0; i < NOE; i++) begin
      do_write(2'd0, i, cplx_pack(32'(i), 32'h0));
      do_write(2'd1, i, cplx_pack(32'h0, 32'(i)));
    end
    do_write(2'd2, 0, 64'h3F800000_00000000);
    run_stream(-1, 0, 0, 0, 0, 0, -1);
    use16 = 1'b0;

    run_stream(1, 3, 0, 0, 0, 0, -1);

    do_write(2'd0, 19, {$urandom, $urandom});
    do_write(2'd3, 2, {$urandom, $urandom});
    run_stream(-1, 0, 0, 0, 0, 1, -1);
    run_stream(-1, 0, 1, 0, 0, 0, -1);

    for (int i = 0; i < NOE; i++) begin
      do_write(2'd0, i, {$urandom, $urandom});
      do_write(2'd1, i, {$urandom, $urandom});
    end
    do_write(2'd2, 5, {$urandom, $urandom});
    run_stream(-1, 0, 1, 1, 0, 0, -1);
    run_stream(-1, 0, 0, 0, 1, 0, -1);

    run_stream(-1, 0, 0, 0, 0, 0, 1);
    run_stream(-1, 0, 1, 0, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
